// File: rtl/inv_shiftrows_stage_if.sv
// inv_shiftrows_stage_if: valid/ready bundle for the InvShiftRows stage (state in, permuted state out, emit counter).
// Latency: none. This file only groups the wires.
// Backpressure: in_ready/out_ready carry the handshakes; the master modport is the upstream/downstream side, the slave modport is the stage.
interface inv_shiftrows_stage_if #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] xfer_cnt;

    // Stage side: consumes input handshake and out_ready, produces the rest.
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_tag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_tag,
        output xfer_cnt
    );

    // Surrounding datapath side.
    modport master (
        output in_valid,
        output in_data,
        output in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_tag,
        input  xfer_cnt
    );
endinterface

// File: rtl/inv_shiftrows_stage.sv
// inv_shiftrows_stage: AES InvShiftRows stage (rows 1..3 rotated right by 1/2/3 bytes) with round-tag sideband.
// Latency: 1 cycle (accept at edge N, out_valid in cycle N+1); sustains 1 state/cycle with out_ready high.
// Backpressure: with INV_SHIFTROWS_SKID_EN an OUT+SKID pair keeps in_ready registered; without it in_ready = !out_valid || out_ready.
module inv_shiftrows_stage #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    inv_shiftrows_stage_if.slave bus
);

    // Occupancy of the output side: EMPTY (OUT empty), ONE (OUT full), TWO (OUT and SKID full).
    // The full flags of OUT and SKID are exactly (state != EMPTY) and (state == TWO).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Byte k sits at [127-8k -: 8], column-major, so byte index = 4*col + row.
    // Output (row r, col c) takes input (row r, col (c-r) mod 4).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return t;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [127:0]     r_out_data;
    logic [TAG_W-1:0] r_out_tag;
    logic [CNT_W-1:0] r_cnt;

    logic [127:0]     w_perm_data;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_acc;
    logic             w_emit;
    logic             w_load_out_in;

`ifdef INV_SHIFTROWS_SKID_EN
    logic [127:0]     r_skid_data;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_in_ready;
    logic             w_load_out_skid;
    logic             w_load_skid;
`endif

    // Permute on the way in so both holding registers only ever contain finished data.
    assign w_perm_data = inv_shift_rows(bus.in_data);

    // out_valid is forced low while rst is high so no handshake can complete in a reset cycle.
    assign w_out_valid = (r_state != ST_EMPTY) && !rst;

`ifdef INV_SHIFTROWS_SKID_EN
    // Registered ready (= SKID not full); rst only masks it, out_ready never reaches it.
    assign w_in_ready = r_in_ready && !rst;
`else
    // Single register: room exists if it is empty or is draining this cycle.
    assign w_in_ready = !rst && (!w_out_valid || bus.out_ready);
`endif

    assign w_acc  = bus.in_valid && w_in_ready;
    assign w_emit = w_out_valid && bus.out_ready;

    // Next occupancy and register load enables from the accept/emit pair.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_out_in = 1'b0;
`ifdef INV_SHIFTROWS_SKID_EN
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
`endif
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt   = ST_ONE;
                    w_load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_acc && w_emit) begin
                    // OUT drains and reloads on the same edge; SKID is left alone.
                    w_load_out_in = 1'b1;
                end else if (w_acc) begin
`ifdef INV_SHIFTROWS_SKID_EN
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
`else
                    // Unreachable without a skid (accept in ONE implies emit); kept safe.
                    w_load_out_in = 1'b1;
`endif
                end else if (w_emit) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
`ifdef INV_SHIFTROWS_SKID_EN
            ST_TWO: begin
                // in_ready is low here, so only an emit can move the state.
                if (w_emit) begin
                    w_state_nxt     = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Occupancy, output register and emit counter; reset discards everything held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_out_data <= '0;
            r_out_tag  <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_out_in) begin
                r_out_data <= w_perm_data;
                r_out_tag  <= bus.in_tag;
            end
`ifdef INV_SHIFTROWS_SKID_EN
            else if (w_load_out_skid) begin
                r_out_data <= r_skid_data;
                r_out_tag  <= r_skid_tag;
            end
`endif
            if (w_emit) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef INV_SHIFTROWS_SKID_EN
    // Skid register and registered ready; ready comes straight from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_data <= '0;
            r_skid_tag  <= '0;
            r_in_ready  <= 1'b1;
        end else begin
            if (w_load_skid) begin
                r_skid_data <= w_perm_data;
                r_skid_tag  <= bus.in_tag;
            end
            r_in_ready <= (w_state_nxt != ST_TWO);
        end
    end
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_tag   = r_out_tag;
    assign bus.xfer_cnt  = r_cnt;

endmodule
